// File: rtl/gate_selftest_ctrl.sv
// rtl/gate_selftest_ctrl.sv - exhaustive truth-table sweep and checker for parallel 2-input gate implementations
module gate_selftest_ctrl #(
  parameter int N_IMPL = 3,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        op_sel,
  input  logic [N_IMPL-1:0] dut_y,
  output logic              dut_a,
  output logic              dut_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IMPL-1:0] fail_mask,
  output logic [1:0]        fail_vec,
  output logic [2:0]        err_count
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE_WAIT, CHECK, FINISH} state_t;

  // DRIVE itself and CHECK each take one cycle, so the wait covers the rest.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE > 1) ? 4'(SETTLE - 2) : 4'd0;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        k;
  logic [1:0]        op_q;
  logic [3:0]        cnt;
  logic              exp_bit;
  logic [N_IMPL-1:0] mismatch;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = DRIVE;
      DRIVE:       state_nxt = (SETTLE == 1) ? CHECK : SETTLE_WAIT;
      SETTLE_WAIT: if (cnt == 4'd0) state_nxt = CHECK;
      CHECK:       state_nxt = (k == 2'd3) ? FINISH : DRIVE;
      FINISH:      state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Case-equality so an X/Z implementation output is reported as a mismatch.
  always_comb begin
    exp_bit  = 1'b0;
    mismatch = '0;
    case (op_q)
      2'b00:   exp_bit = dut_a & dut_b;
      2'b01:   exp_bit = dut_a | dut_b;
      2'b10:   exp_bit = dut_a ^ dut_b;
      default: exp_bit = ~(dut_a & dut_b);
    endcase
    for (int i = 0; i < N_IMPL; i++) begin
      mismatch[i] = (dut_y[i] !== exp_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      op_q      <= 2'd0;
      cnt       <= 4'd0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      fail_vec  <= 2'd0;
      err_count <= 3'd0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (abort) begin
        // Partial fail_mask/fail_vec/err_count are kept for post-mortem.
        busy  <= 1'b0;
        pass  <= 1'b0;
        dut_a <= 1'b0;
        dut_b <= 1'b0;
        k     <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy      <= 1'b1;
              op_q      <= op_sel;
              k         <= 2'd0;
              pass      <= 1'b0;
              fail_mask <= '0;
              fail_vec  <= 2'd0;
              err_count <= 3'd0;
            end
          end
          DRIVE: begin
            {dut_a, dut_b} <= k;
            cnt            <= SETTLE_LOAD;
          end
          SETTLE_WAIT: cnt <= cnt - 4'd1;
          CHECK: begin
            fail_mask <= fail_mask | mismatch;
            if (|mismatch) begin
              err_count <= err_count + 3'd1;
              if (err_count == 3'd0) fail_vec <= k;
            end
            if (k != 2'd3) k <= k + 2'd1;
          end
          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_count == 3'd0);
            dut_a <= 1'b0;
            dut_b <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// tb/tb_gate_selftest_ctrl.sv - scoreboard bench for gate_selftest_ctrl
module tb_gate_selftest_ctrl;

  localparam int S = 2;

  typedef struct {
    logic       pass;
    logic [2:0] mask;
    logic [1:0] vec;
    logic [2:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] op_sel = 2'b00;
  logic [2:0] dut_y;
  logic       dut_a, dut_b, busy, done, pass;
  logic [2:0] fail_mask;
  logic [1:0] fail_vec;
  logic [2:0] err_count;
  logic       stuck = 1'b0;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic [1:0] op1 = 2'b01;
  logic [2:0] y1;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] mask1;
  logic [1:0] fvec1;
  logic [2:0] ecnt1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  int   el, ev;
  logic prev_busy = 1'b0;
  exp_t sb[$];

  // OR-gate implementations; impl 1 optionally stuck-at-0
  assign dut_y = stuck ? {dut_a | dut_b, 1'b0, dut_a | dut_b} : {3{dut_a | dut_b}};
  assign y1    = {3{a1 | b1}};

  gate_selftest_ctrl #(.N_IMPL(3), .SETTLE(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_sel(op_sel),
    .dut_y(dut_y), .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .fail_vec(fail_vec), .err_count(err_count)
  );

  gate_selftest_ctrl #(.N_IMPL(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .op_sel(op1),
    .dut_y(y1), .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(mask1), .fail_vec(fvec1), .err_count(ecnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic [2:0] m, input logic [1:0] v, input logic [2:0] c);
    exp_t e;
    e.pass = p;
    e.mask = m;
    e.vec  = v;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [1:0] op);
    @(posedge clk);
    #1 start = 1'b1;
    op_sel = op;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("sweep_complete", int'(n < 60), 1);
  endtask

  // Monitor: vector timing during a sweep, and scoreboard pop on done
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) start_cyc = cyc;
      if (busy) begin
        el = cyc - start_cyc;
        ev = (el == 0) ? 0 : (el - 1) / (S + 1);
        check("vector", {dut_a, dut_b}, ev);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", cyc - start_cyc, 13);
          check("busy_at_done", busy, 0);
          check("pass", pass, e.pass);
          check("fail_mask", fail_mask, e.mask);
          check("fail_vec", fail_vec, e.vec);
          check("err_count", err_count, e.cnt);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_ab", {dut_a, dut_b}, 0);
    check("rst_mask", fail_mask, 0);
    check("rst_cnt", err_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // correct OR gates checked as OR
    push(1'b1, 3'b000, 2'b00, 3'd0);
    pulse_start(2'b01);
    wait_idle();

    // AND expected against OR gates
    push(1'b0, 3'b111, 2'b01, 3'd2);
    pulse_start(2'b00);
    wait_idle();

    // implementation 1 stuck-at-0
    stuck = 1'b1;
    push(1'b0, 3'b010, 2'b01, 3'd3);
    pulse_start(2'b01);
    wait_idle();
    stuck = 1'b0;

    // abort sampled at edge 7, after the 01 vector has mismatched
    pulse_start(2'b00);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ab", {dut_a, dut_b}, 0);
    check("abort_pass", pass, 0);
    check("abort_done", done, 0);
    check("abort_mask", fail_mask, 3'b111);
    check("abort_cnt", err_count, 1);
    check("abort_vec", fail_vec, 2'b01);
    repeat (20) @(posedge clk);
    push(1'b1, 3'b000, 2'b00, 3'd0);
    pulse_start(2'b01);
    wait_idle();

    // start re-pulsed at edges 3 and 8 with op_sel changing
    push(1'b1, 3'b000, 2'b00, 3'd0);
    pulse_start(2'b01);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    op_sel = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    op_sel = 2'b10;
    @(posedge clk);
    #1 start = 1'b0;
    op_sel = 2'b11;
    wait_idle();

    // start held through edges 0..14: second sweep accepted at edge 14
    push(1'b1, 3'b000, 2'b00, 3'd0);
    push(1'b1, 3'b000, 2'b00, 3'd0);
    @(posedge clk);
    #1 start = 1'b1;
    op_sel = 2'b01;
    repeat (15) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    wait_idle();

    // reset sampled at edge 6 with start held high
    @(posedge clk);
    #1 start = 1'b1;
    op_sel = 2'b00;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ab", {dut_a, dut_b}, 0);
    check("mrst_pass", pass, 0);
    check("mrst_mask", fail_mask, 0);
    check("mrst_vec", fail_vec, 0);
    check("mrst_cnt", err_count, 0);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    push(1'b1, 3'b000, 2'b00, 3'd0);
    pulse_start(2'b01);
    wait_idle();

    // SETTLE=1 instance: done at edge 9
    @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    c0 = cyc;
    n = 0;
    while (!done1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s1_latency", cyc - c0, 9);
    check("s1_pass", pass1, 1);
    check("s1_busy", busy1, 0);
    check("s1_mask", mask1, 0);
    check("s1_cnt", ecnt1, 0);
    check("s1_vec", fvec1, 0);
    check("s1_ab", {a1, b1}, 0);

    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
